// File: rtl/counter_pkg.sv
// Shared constants for the counter family: count direction and limit behaviour.
package counter_pkg;

  // Direction encoding on up_dn
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Limit behaviour encoding for SATURATE
  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

endpackage

// File: rtl/mod_counter.sv
// Synchronous modulo-N up/down counter with clear, clamped load, wrap/saturate
// limit handling, a combinational cascade terminal count and a sticky overflow flag.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Elaboration-time parameter sanity
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2^WIDTH");
  end

  // Upper limit; for MODULUS = 2^WIDTH this is all-ones.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;

  assign at_max  = (q_q == MaxVal);
  assign at_zero = (q_q == '0);

  // Next-state: clr beats load beats en; a limit crossing sets ovf in both modes.
  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d   = (load_val > MaxVal) ? MaxVal : load_val;
      ovf_d = 1'b0;
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (at_max) begin
          ovf_d = 1'b1;
          q_d   = (SATURATE == CNT_SAT) ? q_q : '0;
        end else begin
          q_d = q_q + One;
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          q_d   = (SATURATE == CNT_SAT) ? q_q : MaxVal;
        end else begin
          q_d = q_q - One;
        end
      end
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  // Terminal count: next edge crosses the limit; held low while in reset.
  always_comb begin
    tc = rst & en & ((up_dn == CNT_UP) ? at_max : at_zero);
  end

  assign q   = q_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: wrap and saturate instances (WIDTH 4, MODULUS 10) share
// stimulus; a two-stage MODULUS 16 cascade checks carry propagation across 8 bits.
module tb_mod_counter;

  localparam int M = 10;

  logic       clk;
  logic       rst;
  logic       en, up_dn, clr, load;
  logic [3:0] load_val;
  logic       c_en;

  logic [3:0] w_q, s_q, lo_q, hi_q;
  logic       w_tc, s_tc, lo_tc, hi_tc;
  logic       w_ovf, s_ovf, lo_ovf, hi_ovf;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference state
  int wq, wovf, sq, sovf, ccnt;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .q(w_q), .tc(w_tc), .ovf(w_ovf)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .q(s_q), .tc(s_tc), .ovf(s_ovf)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(lo_q), .tc(lo_tc), .ovf(lo_ovf)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(hi_q), .tc(hi_tc), .ovf(hi_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behaviour of one modulo-M counter on a clock edge, straight from the rules.
  task automatic model_step(input bit sat, inout int q, inout int ovf);
    if (clr) begin
      q = 0; ovf = 0;
    end else if (load) begin
      q = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
      ovf = 0;
    end else if (en) begin
      if (up_dn) begin
        if (q == M - 1) begin ovf = 1; q = sat ? q : 0; end
        else q = q + 1;
      end else begin
        if (q == 0) begin ovf = 1; q = sat ? q : M - 1; end
        else q = q - 1;
      end
    end
  endtask

  function automatic int exp_tc(input int q);
    if (!rst || !en) return 0;
    return up_dn ? int'(q == M - 1) : int'(q == 0);
  endfunction

  task automatic model_reset();
    wq = 0; wovf = 0; sq = 0; sovf = 0; ccnt = 0;
  endtask

  // Advance one edge: update models from the inputs sampled, then settle.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_step(1'b0, wq, wovf);
      model_step(1'b1, sq, sovf);
      if (c_en) ccnt = (ccnt + 1) % 256;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":w_q"}, 32'(w_q), wq);
    check({tag, ":w_ovf"}, 32'(w_ovf), wovf);
    check({tag, ":w_tc"}, 32'(w_tc), exp_tc(wq));
    check({tag, ":s_q"}, 32'(s_q), sq);
    check({tag, ":s_ovf"}, 32'(s_ovf), sovf);
    check({tag, ":s_tc"}, 32'(s_tc), exp_tc(sq));
    check({tag, ":casc"}, 32'({hi_q, lo_q}), ccnt);
    check({tag, ":lo_tc"}, 32'(lo_tc), (rst && c_en && (ccnt % 16 == 15)) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; up_dn = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = 4'd0; c_en = 1'b0;
    model_reset();
    #1;
    // In reset with en=1, down, q=0: tc must still be gated low
    check("rst_w_tc", 32'(w_tc), 0);
    check("rst_s_tc", 32'(s_tc), 0);
    check_all("reset");
    tick();
    check_all("reset_hold");

    // Release between edges, count up 12 cycles through the wrap
    #2 rst = 1'b1; up_dn = 1'b1; en = 1'b1;
    #1 check_all("up_pre");
    for (int i = 0; i < 12; i++) begin
      tick();
      check_all("up");
    end

    // Clear, then count down from 0: 9, 8, 7
    clr = 1'b1; tick(); clr = 1'b0; up_dn = 1'b0;
    #1 check_all("clr");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("down");
    end

    // Load 8 then count up 4: saturate instance sits at 9
    en = 1'b0; load = 1'b1; load_val = 4'd8; tick(); load = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    #1 check_all("load8");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("sat_up");
    end
    check("sat_hold_q", 32'(s_q), 9);

    // Clamped load, load beating en, then clr beating load
    load = 1'b1; load_val = 4'd13; tick();
    check_all("load13");
    check("clamp_q", 32'(w_q), 9);
    clr = 1'b1; tick(); clr = 1'b0; load = 1'b0;
    check_all("clr_load");

    // Count to 6, drop reset mid-cycle, release, first edge gives 1
    up_dn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_q", 32'(w_q), 6);
    up_dn = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    #1 rst = 1'b1; up_dn = 1'b1;
    tick();
    check_all("post_rst");
    check("post_rst_q", 32'(w_q), 1);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      en       = 1'($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      clr      = 1'($urandom_range(0, 19) == 0);
      load     = 1'($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      #1 check_all("rnd_pre");
      tick();
      check_all("rnd");
    end
    en = 1'b0; clr = 1'b0; load = 1'b0;

    // Cascade: run past 255 to see the 8-bit wrap
    c_en = 1'b1;
    #1 check_all("casc_pre");
    for (int i = 0; i < 270; i++) begin
      tick();
      check_all("casc");
    end
    c_en = 1'b0;
    tick();
    check_all("casc_stop");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
